// File: rtl/stream_serializer_pkg.sv
// Shared types and helpers for the stream width-down serializer.
package stream_serializer_pkg;

  // Serializer control state: IDLE holds no word, BUSY is presenting beats.
  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_BUSY = 1'b1
  } ser_state_e;

  // Width of the beat-length field needed to count 0..ratio-1.
  function automatic int unsigned ser_len_bits(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/stream_serializer.sv
// stream_serializer: accepts one wide word per w_ handshake and emits it as
// 1..RATIO narrow beats on the r_ side, least-significant slice first.
// Optional feature: define STREAM_SER_LAST_EN to add the r_last_o framing port.
module stream_serializer
  import stream_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned RATIO      = 4,
  parameter int unsigned OUT_WIDTH  = DATA_WIDTH / RATIO,
  parameter int unsigned LEN_WIDTH  = ser_len_bits(RATIO)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  w_ready_o,
  input  logic                  w_valid_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic [LEN_WIDTH-1:0]  w_len_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
`ifdef STREAM_SER_LAST_EN
  output logic                  r_last_o,
`endif
  output logic [OUT_WIDTH-1:0]  r_data_o
);

  ser_state_e            state_q;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  busy;
  logic                  at_last;
  logic                  load;
  logic [OUT_WIDTH-1:0]  slice [RATIO];

  assign busy    = (state_q == SER_BUSY);
  assign at_last = (beat_q == len_q);

  // Ready while empty, or when the final beat leaves this cycle so the next
  // word can be loaded without a bubble.
  assign w_ready_o = !busy || (r_ready_i && at_last);
  assign load      = w_valid_i && w_ready_o;

  // Break the held word into beat-sized slices for the output mux.
  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    assign slice[g] = data_q[g*OUT_WIDTH +: OUT_WIDTH];
  end

  assign r_valid_o = busy;
  assign r_data_o  = slice[beat_q];

`ifdef STREAM_SER_LAST_EN
  assign r_last_o = busy && at_last;
`endif

  // Load a new word, advance the beat index on each accepted beat, or return
  // to idle after the final beat when no follow-on word is offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SER_IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else if (load) begin
      state_q <= SER_BUSY;
      beat_q  <= '0;
      len_q   <= w_len_i;
      data_q  <= w_data_i;
    end else if (busy && r_ready_i) begin
      if (!at_last) begin
        beat_q <= beat_q + LEN_WIDTH'(1);
      end else begin
        state_q <= SER_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: directed scenarios plus a randomised stream,
// all checked against a beat-queue model of the expected output stream.
module tb_stream_serializer;

  localparam int DW = 128;
  localparam int OW = 32;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic [LW-1:0] w_len;
  logic          r_ready;
  logic          w_ready;
  logic          r_valid;
  logic [OW-1:0] r_data;
`ifdef STREAM_SER_LAST_EN
  logic          r_last;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [OW-1:0] d;
    bit            last;
  } beat_t;

  beat_t q[$];
  int    pushed_beats = 0;
  int    popped_beats = 0;
  bit    rand_done    = 0;

  stream_serializer #(
    .DATA_WIDTH(DW),
    .RATIO(4),
    .OUT_WIDTH(OW),
    .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .w_ready_o(w_ready),
    .w_valid_i(w_valid),
    .w_data_i(w_data),
    .w_len_i(w_len),
    .r_valid_o(r_valid),
    .r_ready_i(r_ready),
`ifdef STREAM_SER_LAST_EN
    .r_last_o(r_last),
`endif
    .r_data_o(r_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted word becomes len+1 queued beats; the DUT must
  // present the queue head, and is ready when at most the current last beat
  // remains and it is being consumed.
  always @(negedge clk) begin
    bit exp_wr;
    if (!rst_n) begin
      q.delete();
      chk("rst_rvalid", r_valid, 0);
      chk("rst_wready", w_ready, 1);
      chk("rst_rdata", r_data, 0);
`ifdef STREAM_SER_LAST_EN
      chk("rst_rlast", r_last, 0);
`endif
    end else begin
      exp_wr = (q.size() == 0) || (q.size() == 1 && r_ready);
      chk("m_rvalid", r_valid, q.size() != 0);
      chk("m_wready", w_ready, exp_wr);
      if (q.size() != 0) begin
        chk("m_rdata", r_data, q[0].d);
`ifdef STREAM_SER_LAST_EN
        chk("m_rlast", r_last, q[0].last);
`endif
      end
`ifdef STREAM_SER_LAST_EN
      else chk("m_rlast_idle", r_last, 0);
`endif
      if (r_valid && r_ready && q.size() != 0) begin
        void'(q.pop_front());
        popped_beats++;
      end
      if (w_valid && w_ready) begin
        for (int i = 0; i <= int'(w_len); i++) begin
          beat_t b;
          b.d    = w_data[i*OW +: OW];
          b.last = (i == int'(w_len));
          q.push_back(b);
          pushed_beats++;
        end
      end
    end
  end

  // Offer one word and hold it until the DUT takes it.
  task automatic send(input logic [DW-1:0] d, input logic [LW-1:0] l);
    int n = 0;
    w_valid = 1'b1;
    w_data  = d;
    w_len   = l;
    @(negedge clk);
    while (!w_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!w_ready) chk("send_timeout", w_ready, 1);
    @(posedge clk);
    #1 w_valid = 1'b0;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] exp1 [4];
    logic [DW-1:0] d4;
    bit            vld [8];
    bit            wr  [8];
    int            vcnt;
    int            wlow;
    int            n;

    exp1[0] = 32'hFFFFFFFF;
    exp1[1] = 32'h00000000;
    exp1[2] = 32'h22221111;
    exp1[3] = 32'h44443333;

    rst_n   = 1'b1;
    w_valid = 1'b0;
    w_data  = '0;
    w_len   = '0;
    r_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_rvalid", r_valid, 0);
    chk("reset_wready", w_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    r_ready = 1'b1;

    // 1: single word, four beats LSB slice first
    sync();
    send(128'h44443333_22221111_00000000_FFFFFFFF, 2'd3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid", r_valid, 1);
      chk("t1_data", r_data, exp1[k]);
`ifdef STREAM_SER_LAST_EN
      chk("t1_last", r_last, k == 3);
`endif
    end
    @(negedge clk);
    chk("t1_idle", r_valid, 0);

    // 2: back-to-back len=3 then len=1, no bubble
    sync();
    fork
      begin
        send(128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 2'd3);
        send(128'h0_0000_0000_0000_0000_5555_6666_7777_8888, 2'd1);
      end
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          vld[i] = r_valid;
          wr[i]  = w_ready;
        end
      end
    join
    vcnt = 0;
    for (int i = 1; i <= 6; i++) vcnt += int'(vld[i]);
    chk("t2_consec_beats", vcnt, 6);
    chk("t2_end_idle", vld[7], 0);
    chk("t2_wready_pattern", {wr[1], wr[2], wr[3], wr[4], wr[5]}, 5'b00010);

    // 3: len=0 words stream at one word per cycle
    sync();
    fork
      begin
        for (int i = 0; i < 8; i++) send({4{$urandom()}}, 2'd0);
      end
      begin
        vcnt = 0;
        wlow = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          vcnt += int'(r_valid);
          wlow += int'(!w_ready);
        end
      end
    join
    chk("t3_valid_count", vcnt, 8);
    chk("t3_wready_low", wlow, 0);

    // 4: backpressure holds beat 2 stable
    sync();
    d4 = 128'h4D4D4D4D_3C3C3C3C_2B2B2B2B_1A1A1A1A;
    send(d4, 2'd3);
    @(posedge clk);
    #1 r_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", r_valid, 1);
      chk("t4_hold_data", r_data, 32'h2B2B2B2B);
      chk("t4_hold_wready", w_ready, 0);
    end
    @(posedge clk);
    #1 r_ready = 1'b1;
    @(negedge clk);
    chk("t4_resume_data", r_data, 32'h2B2B2B2B);
    repeat (3) @(negedge clk);
    chk("t4_idle", r_valid, 0);

    // 5: asynchronous reset while a word is in flight
    sync();
    send(128'h99999999_88888888_77777777_66666666, 2'd3);
    @(negedge clk);
    chk("t5_pending", r_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_rvalid", r_valid, 0);
    chk("t5_rst_wready", w_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_stale", r_valid, 0);
    end

    // 6: random gaps, lengths and backpressure against the model
    sync();
    pushed_beats = 0;
    popped_beats = 0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          int gap;
          gap = $urandom_range(0, 2);
          if (gap != 0) begin
            repeat (gap) @(posedge clk);
            #1;
          end
          send({$urandom(), $urandom(), $urandom(), $urandom()}, LW'($urandom_range(0, 3)));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 r_ready = ($urandom_range(0, 3) != 0);
        end
        r_ready = 1'b1;
      end
    join
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("t6_drained", q.size(), 0);
    chk("t6_beats_out", popped_beats, pushed_beats);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
